decodificador_fila: RTL

DECODIFICADOR_FILA -- requirements
Module: decodificador_fila

---
 rtl/decodificador_fila.sv | 134 +++++++++++++
 1 files changed

// File: rtl/decodificador_fila.sv
// Gray-to-binary decoder into a 4-deep FIFO; head on Q one cycle after capture, ack pops, words offered while full are dropped (sticky overflow).
// Optional DECODIFICADOR_SEG7_EN adds a registered seven-segment view of the head entry.
module decodificador_fila (
  input  logic       clk,
  input  logic       reset,
  input  logic       S3,
  input  logic       S2,
  input  logic       S1,
  input  logic       S0,
  input  logic       ready,
  input  logic       ack,
  output logic [3:0] Q,
  output logic       valid,
  output logic [2:0] count,
  output logic       full,
  output logic       overflow
`ifdef DECODIFICADOR_SEG7_EN
  ,
  output logic [6:0] seg
`endif
);

  logic       r_ready_q;
  logic       r_armed;
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       r_overflow;
  logic [3:0] r_mem [4];
  logic [3:0] r_head;

  logic       w_valid;
  logic       w_full;
  logic       w_cap;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic [3:0] w_dec;
  logic [1:0] w_rd_ptr_nxt;
  logic [2:0] w_count_nxt;
  logic [3:0] w_head_nxt;

  assign w_valid      = (r_count != 3'd0);
  assign w_full       = (r_count == 3'd4);
  assign w_dec        = {S3, S3 ^ S2, S3 ^ S2 ^ S1, S3 ^ S2 ^ S1 ^ S0};
  // r_armed blocks a capture until ready has been seen low after reset
  assign w_cap        = ready & ~r_ready_q & r_armed;
  assign w_pop        = w_valid & ack;
  assign w_push       = w_cap & (~w_full | w_pop);
  assign w_drop       = w_cap & w_full & ~w_pop;
  assign w_rd_ptr_nxt = r_rd_ptr + {1'b0, w_pop};
  assign w_count_nxt  = r_count + {2'b00, w_push} - {2'b00, w_pop};

  // Next head: the word written this cycle if it lands at the new read slot
  always_comb begin
    w_head_nxt = 4'd0;
    if (w_count_nxt != 3'd0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt))
        w_head_nxt = w_dec;
      else
        w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push)
      r_mem[r_wr_ptr] <= w_dec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready_q  <= 1'b0;
      r_armed    <= 1'b0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
      r_head     <= 4'd0;
    end else begin
      r_ready_q <= ready;
      r_armed   <= r_armed | ~ready;
      r_wr_ptr  <= r_wr_ptr + {1'b0, w_push};
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_head    <= w_head_nxt;
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  assign Q        = r_head;
  assign valid    = w_valid;
  assign count    = r_count;
  assign full     = w_full;
  assign overflow = r_overflow;

`ifdef DECODIFICADOR_SEG7_EN
  logic [6:0] r_seg;

  // Segment order {g,f,e,d,c,b,a}, active high
  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    case (d)
      4'h0: f_seg7 = 7'b0111111;
      4'h1: f_seg7 = 7'b0000110;
      4'h2: f_seg7 = 7'b1011011;
      4'h3: f_seg7 = 7'b1001111;
      4'h4: f_seg7 = 7'b1100110;
      4'h5: f_seg7 = 7'b1101101;
      4'h6: f_seg7 = 7'b1111101;
      4'h7: f_seg7 = 7'b0000111;
      4'h8: f_seg7 = 7'b1111111;
      4'h9: f_seg7 = 7'b1101111;
      4'hA: f_seg7 = 7'b1110111;
      4'hB: f_seg7 = 7'b1111100;
      4'hC: f_seg7 = 7'b0111001;
      4'hD: f_seg7 = 7'b1011110;
      4'hE: f_seg7 = 7'b1111001;
      default: f_seg7 = 7'b1110001;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      r_seg <= 7'd0;
    else if (w_count_nxt != 3'd0)
      r_seg <= f_seg7(w_head_nxt);
    else
      r_seg <= 7'd0;
  end

  assign seg = r_seg;
`endif

endmodule
